l2_cache_control: RTL and testbench
===================================

# l2_cache_control

Control FSM for the 8-way, 8-set, write-back/write-allocate L2 cache. It sits between the L1/arbiter request port, the L2 cache datapath and physical memory. It decodes hit/valid/dirty status and the 7-bit pseudo-LRU word from the datapath. It drives way loads, LRU updates, mux selects and the pmem read/write handshake.

## Interface
Parameters: none. All widths are fixed by package types.

Ports (clock and reset first):
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  arbiter read request; held until mem_resp
- mem_write  in  1  arbiter write request (full cacheline); held until mem_resp
- mem_resp  out  1  request complete this cycle
- state  in  lc3b_L2_state  per-way hit, v_out, d_out
- lru_out  in  7  PLRU word of the addressed set
- ctl  out  lc3b_L2_ctl  per-way load_d, load_v, load_TD, d_in, v_in; load_lru
- lru_in  out  7  next PLRU word
- pmemwdata_sel  out  3  way select for the read-data / writeback-data mux
- pmemaddr_sel  out  4  0 = request address; 1+w = tag of way w (w = 0..7)
- pmem_read  out  1  memory read; also selects fill data in the datapath write logic
- pmem_write  out  1  memory write (writeback)
- pmem_resp  in  1  memory transaction done

## Operation
- States: IDLE, WRITEBACK, ALLOCATE.
- **IDLE, no request:** all outputs 0.
- **IDLE, request, some state.wayN.hit:**
  - mem_resp=1 and pmemwdata_sel=N in the same cycle.
  - load_lru=1; lru_in = PLRU update pointing away from N.
  - On mem_write, also load_TD=1, load_d=1 and d_in=1 on way N.
  - Stay in IDLE.
- **IDLE, request, no hit (miss):**
  - Victim = lowest-index way with v_out=0. If all ways are valid, victim = PLRU victim of lru_out.
  - The victim is registered into victim_q.
  - Next state is WRITEBACK if the victim's d_out=1, else ALLOCATE.
- **WRITEBACK:**
  - pmem_write=1, pmemaddr_sel=1+victim_q, pmemwdata_sel=victim_q.
  - On pmem_resp, go to ALLOCATE.
- **ALLOCATE:**
  - pmem_read=1, pmemaddr_sel=0.
  - On pmem_resp: load_TD=1, load_v=1, v_in=1, load_d=1 and d_in=0 on way victim_q; go to IDLE.
  - IDLE then re-evaluates, hits, and completes the request (read data, or the write merge with dirty set).
- **PLRU encoding:**
  - Bit 0 is the root: 0 means victim in ways 0-3, 1 means ways 4-7.
  - Bit 1 covers ways 0-3: 0 means 0-1, 1 means 2-3. Bit 2 covers ways 4-7 the same way.
  - Bits 3..6 cover the pairs (0,1), (2,3), (4,5), (6,7): 0 means the lower way.
  - An access sets each bit on the accessed way's path so that it points to the other subtree. Bits off that path are unchanged.
- **Multiple hits:** cannot occur. The lowest index is chosen defensively.
- **Simultaneous mem_read and mem_write:** treated as a write.
- The request is not re-sampled while in WRITEBACK or ALLOCATE. The arbiter must hold the address stable.

## Timing
- Hit: mem_resp in the first cycle the request is seen (combinational from state).
- Clean miss: ALLOCATE for k cycles (k = pmem latency), then the hit cycle. mem_resp arrives k+2 cycles after the request.
- Dirty miss: adds j WRITEBACK cycles (j = writeback latency).
- pmem_read and pmem_write are held high until the cycle in which pmem_resp is sampled. They are low in the following cycle.
- Reset (including mid-WRITEBACK/ALLOCATE): next state IDLE, victim_q=0, counters=0. All outputs are 0 in the cycle after rst unless a new request is present. An abandoned pmem transaction is not completed.

## Configuration
- **L2_PERF_CNT_EN defined:** adds outputs hit_count and miss_count (16 bits each, saturating at 0xFFFF).
  - hit_count increments on each hit-completed request when it did not pass through ALLOCATE.
  - miss_count increments on each IDLE→miss transition.
  - Both clear on rst.
- **Undefined:** ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package lc3b_types holds:
  - lc3b_L2_ctl and lc3b_L2_state (existing).
  - New: lc3b_L2_ctl_state enum {IDLE, WRITEBACK, ALLOCATE}.
  - New: constant L2_PMEMADDR_REQ = 4'd0.
- One combinational sub-module, l2_plru:
  - Inputs: lru (7 bits), access_way (3 bits).
  - Outputs: lru_next (7 bits), victim (3 bits).

## Test plan
- **Read to empty cache**, address 0x1234 (set 1, tag 0x12): ALLOCATE with pmemaddr_sel=0; way0 loaded with v=1, d=0. mem_resp at k+2. lru_in for set 1 = 7'b0001011 (bits 0, 1, 3 set).
- **Read hit** on 0x1234 after fill: mem_resp the same cycle, pmemwdata_sel=0, no pmem activity.
- **Write hit** on 0x1234: way0 load_TD=1 and d_in=1 in the response cycle; the next read shows state.way0.d_out=1.
- **Fill all 8 ways of set 1** with tags 0x10..0x17, all dirty, then write tag 0x20:
  - WRITEBACK to PLRU victim w with pmemaddr_sel=1+w, pmemwdata_sel=w.
  - Then ALLOCATE; the final way w has tag 0x20 and d=1.
- **Assert rst mid-ALLOCATE:** pmem_read=0 and state=IDLE the next cycle; a fresh read then completes normally.
- **With L2_PERF_CNT_EN:** 3 misses + 5 hits give miss_count=3, hit_count=5. A counter preset near saturation holds at 0xFFFF.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared L2 cache types: per-way status/control bundles and the controller state encoding.
// Each bundle lists way7 first so that way N sits at index N of a packed [7:0] array.
package lc3b_types;

  typedef struct packed {
    logic hit;
    logic v_out;
    logic d_out;
  } lc3b_L2_way_state;

  typedef struct packed {
    lc3b_L2_way_state way7;
    lc3b_L2_way_state way6;
    lc3b_L2_way_state way5;
    lc3b_L2_way_state way4;
    lc3b_L2_way_state way3;
    lc3b_L2_way_state way2;
    lc3b_L2_way_state way1;
    lc3b_L2_way_state way0;
  } lc3b_L2_state;

  typedef struct packed {
    logic load_d;
    logic load_v;
    logic load_TD;
    logic d_in;
    logic v_in;
  } lc3b_L2_way_ctl;

  typedef struct packed {
    logic           load_lru;
    lc3b_L2_way_ctl way7;
    lc3b_L2_way_ctl way6;
    lc3b_L2_way_ctl way5;
    lc3b_L2_way_ctl way4;
    lc3b_L2_way_ctl way3;
    lc3b_L2_way_ctl way2;
    lc3b_L2_way_ctl way1;
    lc3b_L2_way_ctl way0;
  } lc3b_L2_ctl;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } lc3b_L2_ctl_state;

  localparam logic [3:0] L2_PMEMADDR_REQ = 4'd0;

endpackage

// File: rtl/l2_cache_control_plru.sv
// Tree pseudo-LRU for 8 ways: victim selection and post-access update.
// Bit 0 is the root, bits 1/2 the halves, bits 3..6 the pairs; 0 always points low.
module l2_plru (
  input  logic [6:0] lru,
  input  logic [2:0] access_way,
  output logic [6:0] lru_next,
  output logic [2:0] victim
);

  logic [1:0] pair_v;
  logic [3:0] lru_pairs;
  logic [3:0] pairs_next;

  always_comb begin
    lru_pairs = lru[6:3];
    pair_v    = {lru[0], (lru[0] ? lru[2] : lru[1])};
    victim    = {pair_v, lru_pairs[pair_v]};
  end

  // Every node on the accessed path is turned toward the sibling subtree.
  always_comb begin
    lru_next    = lru;
    lru_next[0] = ~access_way[2];
    if (access_way[2]) begin
      lru_next[2] = ~access_way[1];
    end else begin
      lru_next[1] = ~access_way[1];
    end
    pairs_next                   = lru[6:3];
    pairs_next[access_way[2:1]]  = ~access_way[0];
    lru_next[6:3]                = pairs_next;
  end

endmodule

// File: rtl/l2_cache_control.sv
// Control FSM for the 8-way, 8-set write-back/write-allocate L2 cache.
// Optional hit/miss counters are built when L2_PERF_CNT_EN is defined.
module l2_cache_control
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  output logic         mem_resp,
  input  lc3b_L2_state state,
  input  logic [6:0]   lru_out,
  output lc3b_L2_ctl   ctl,
  output logic [6:0]   lru_in,
  output logic [2:0]   pmemwdata_sel,
  output logic [3:0]   pmemaddr_sel,
  output logic         pmem_read,
  output logic         pmem_write,
  input  logic         pmem_resp
`ifdef L2_PERF_CNT_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`endif
);

  lc3b_L2_ctl_state      state_q, state_d;
  logic [2:0]            victim_q, victim_d;

  lc3b_L2_way_state [7:0] ways;
  lc3b_L2_way_ctl   [7:0] way_ctl;
  logic                   load_lru;
  logic [7:0]             hit_vec, valid_vec, dirty_vec;
  logic                   req, any_hit, all_valid;
  logic [2:0]             hit_way, free_way, miss_victim;
  logic [6:0]             plru_next;
  logic [2:0]             plru_victim;

  assign ways = state;
  assign req  = mem_read | mem_write;

  for (genvar gi = 0; gi < 8; gi++) begin : g_way_status
    assign hit_vec[gi]   = ways[gi].hit;
    assign valid_vec[gi] = ways[gi].v_out;
    assign dirty_vec[gi] = ways[gi].d_out;
  end

  // Scanning downward leaves the lowest matching index in place.
  always_comb begin
    hit_way  = 3'd0;
    free_way = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = 3'(i);
      if (!valid_vec[i]) free_way = 3'(i);
    end
  end

  assign any_hit     = |hit_vec;
  assign all_valid   = &valid_vec;
  assign miss_victim = all_valid ? plru_victim : free_way;

  l2_plru u_plru (
    .lru        (lru_out),
    .access_way (hit_way),
    .lru_next   (plru_next),
    .victim     (plru_victim)
  );

  always_comb begin
    state_d       = state_q;
    victim_d      = victim_q;
    mem_resp      = 1'b0;
    way_ctl       = '0;
    load_lru      = 1'b0;
    lru_in        = 7'd0;
    pmemwdata_sel = 3'd0;
    pmemaddr_sel  = L2_PMEMADDR_REQ;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (any_hit) begin
            mem_resp      = 1'b1;
            pmemwdata_sel = hit_way;
            load_lru      = 1'b1;
            lru_in        = plru_next;
            // A simultaneous read+write is serviced as a write.
            if (mem_write) begin
              way_ctl[hit_way].load_TD = 1'b1;
              way_ctl[hit_way].load_d  = 1'b1;
              way_ctl[hit_way].d_in    = 1'b1;
            end
          end else begin
            victim_d = miss_victim;
            state_d  = dirty_vec[miss_victim] ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmemaddr_sel  = 4'd1 + {1'b0, victim_q};
        pmemwdata_sel = victim_q;
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          way_ctl[victim_q].load_TD = 1'b1;
          way_ctl[victim_q].load_v  = 1'b1;
          way_ctl[victim_q].v_in    = 1'b1;
          way_ctl[victim_q].load_d  = 1'b1;
          way_ctl[victim_q].d_in    = 1'b0;
          state_d                   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ctl = {load_lru, way_ctl};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

`ifdef L2_PERF_CNT_EN
  logic        filled_q, filled_d;
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic        hit_done, miss_start;

  assign hit_done   = (state_q == IDLE) && req && any_hit;
  assign miss_start = (state_q == IDLE) && req && !any_hit;

  // filled_q marks the post-fill hit so it is not counted as a hit.
  always_comb begin
    filled_d   = filled_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if ((state_q == ALLOCATE) && pmem_resp) begin
      filled_d = 1'b1;
    end else if (hit_done) begin
      filled_d = 1'b0;
    end
    if (hit_done && !filled_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
    if (miss_start && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filled_q   <= 1'b0;
      hit_cnt_q  <= 16'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      filled_q   <= filled_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed bench for l2_cache_control with a behavioural tag/valid/dirty/LRU store and pmem responder.
// Address split: tag = addr[15:8], set = addr[7:5].
module tb_l2_cache_control;
  import lc3b_types::*;

  localparam int PM_LAT = 3;

  logic         clk;
  logic         rst;
  logic         mem_read, mem_write, mem_resp;
  lc3b_L2_state st;
  logic [6:0]   lru_out, lru_in;
  lc3b_L2_ctl   ctl;
  logic [2:0]   pmemwdata_sel;
  logic [3:0]   pmemaddr_sel;
  logic         pmem_read, pmem_write, pmem_resp;
`ifdef L2_PERF_CNT_EN
  logic [15:0]  hit_count, miss_count;
`endif

  l2_cache_control dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_resp      (mem_resp),
    .state         (st),
    .lru_out       (lru_out),
    .ctl           (ctl),
    .lru_in        (lru_in),
    .pmemwdata_sel (pmemwdata_sel),
    .pmemaddr_sel  (pmemaddr_sel),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_resp     (pmem_resp)
`ifdef L2_PERF_CNT_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural datapath store ----------------
  logic [15:0] addr;
  logic [2:0]  cur_set;
  logic [7:0]  cur_tag;
  logic [7:0]  tag_m [8][8];
  logic        v_m   [8][8];
  logic        d_m   [8][8];
  logic [6:0]  lru_m [8];

  lc3b_L2_way_state [7:0] st_ways;
  lc3b_L2_way_ctl   [7:0] ctl_ways;
  logic                   ctl_lru;
  logic [7:0] vec_load_v, vec_load_d, vec_load_td, vec_d_in, vec_dout;

  assign cur_set = addr[7:5];
  assign cur_tag = addr[15:8];
  assign {ctl_lru, ctl_ways} = ctl;
  assign st = st_ways;
  assign lru_out = lru_m[cur_set];

  always_comb begin
    st_ways = '0;
    vec_load_v = '0; vec_load_d = '0; vec_load_td = '0; vec_d_in = '0; vec_dout = '0;
    for (int w = 0; w < 8; w++) begin
      st_ways[w].hit   = v_m[cur_set][w] && (tag_m[cur_set][w] == cur_tag);
      st_ways[w].v_out = v_m[cur_set][w];
      st_ways[w].d_out = d_m[cur_set][w];
      vec_load_v[w]    = ctl_ways[w].load_v;
      vec_load_d[w]    = ctl_ways[w].load_d;
      vec_load_td[w]   = ctl_ways[w].load_TD;
      vec_d_in[w]      = ctl_ways[w].d_in;
      vec_dout[w]      = d_m[cur_set][w];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 8; s++) begin
        lru_m[s] <= 7'd0;
        for (int w = 0; w < 8; w++) begin
          v_m[s][w] <= 1'b0;
          d_m[s][w] <= 1'b0;
        end
      end
    end else begin
      for (int w = 0; w < 8; w++) begin
        if (ctl_ways[w].load_TD) tag_m[cur_set][w] <= cur_tag;
        if (ctl_ways[w].load_v)  v_m[cur_set][w]   <= ctl_ways[w].v_in;
        if (ctl_ways[w].load_d)  d_m[cur_set][w]   <= ctl_ways[w].d_in;
      end
      if (ctl_lru) lru_m[cur_set] <= lru_in;
    end
  end

  // ---------------- pmem responder: pmem_resp in the PM_LAT-th cycle of a held request ----------------
  int pm_cnt = 0;
  initial pmem_resp = 1'b0;
  always begin
    @(posedge clk);
    #2;
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      pm_cnt    = 0;
    end
    if (rst || !(pmem_read || pmem_write)) begin
      pm_cnt    = 0;
      pmem_resp = 1'b0;
    end else begin
      pm_cnt++;
      if (pm_cnt == PM_LAT) pmem_resp = 1'b1;
    end
  end

  // ---------------- request driver ----------------
  int         lat;
  logic       wb_seen, alloc_seen;
  logic [3:0] wb_asel, alloc_asel;
  logic [2:0] wb_dsel, r_dsel;
  logic [6:0] r_lru;
  logic [7:0] fill_v, fill_ld, fill_din, r_td, r_din, r_dout;
  int         exp_hits = 0;
  int         exp_miss = 0;

  // Called just after a rising edge; returns just after the edge that closes the response cycle.
  task automatic do_req(input logic [15:0] a, input logic rd, input logic wr);
    bit done;
    addr = a; mem_read = rd; mem_write = wr;
    lat = 0; wb_seen = 0; alloc_seen = 0; wb_asel = 0; wb_dsel = 0; alloc_asel = 4'hF;
    fill_v = 0; fill_ld = 0; fill_din = 8'hFF; r_dsel = 0; r_lru = 0; r_td = 0; r_din = 0; r_dout = 0;
    done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      lat++;
      if (pmem_write) begin wb_seen = 1; wb_asel = pmemaddr_sel; wb_dsel = pmemwdata_sel; end
      if (pmem_read) begin alloc_seen = 1; alloc_asel = pmemaddr_sel; end
      if (pmem_read && pmem_resp) begin fill_v = vec_load_v; fill_ld = vec_load_d; fill_din = vec_d_in; end
      if (mem_resp) begin
        done = 1; r_dsel = pmemwdata_sel; r_lru = lru_in; r_td = vec_load_td; r_din = vec_d_in; r_dout = vec_dout;
      end
      @(posedge clk);
      #1;
    end
    mem_read = 0; mem_write = 0;
    if (!done) check_val("req_timeout", 64'd0, 64'd1);
    if (alloc_seen) exp_miss++;
    else if (done) exp_hits++;
    $display("req addr=%h rd=%0d wr=%0d lat=%0d wb=%0d alloc=%0d dsel=%0d lru_in=%b",
             a, rd, wr, lat, wb_seen, alloc_seen, r_dsel, r_lru);
  endtask

  logic [7:0] fill_lat [8];

  initial begin
    rst = 1; mem_read = 0; mem_write = 0; addr = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check_val("reset_outputs",
              {6'd0, mem_resp, ctl, lru_in, pmemwdata_sel, pmemaddr_sel, pmem_read, pmem_write}, 64'd0);
    check_val("reset_state", 64'(dut.state_q), 64'(IDLE));
    @(posedge clk); #1;

    // Clean miss into an empty set
    do_req(16'h1234, 1, 0);
    check_val("miss_lat", 64'(lat), 64'(PM_LAT + 2));
    check_val("miss_no_wb", 64'(wb_seen), 64'd0);
    check_val("miss_alloc", 64'(alloc_seen), 64'd1);
    check_val("miss_alloc_asel", 64'(alloc_asel), 64'd0);
    check_val("miss_fill_v", 64'(fill_v), 64'h01);
    check_val("miss_fill_ld", 64'(fill_ld), 64'h01);
    check_val("miss_fill_din", 64'(fill_din), 64'h00);
    check_val("miss_resp_dsel", 64'(r_dsel), 64'd0);
    check_val("miss_lru_in", 64'(r_lru), 64'b0001011);

    // Read hit
    do_req(16'h1234, 1, 0);
    check_val("rhit_lat", 64'(lat), 64'd1);
    check_val("rhit_no_alloc", 64'(alloc_seen), 64'd0);
    check_val("rhit_no_wb", 64'(wb_seen), 64'd0);
    check_val("rhit_dsel", 64'(r_dsel), 64'd0);

    // Write hit sets dirty on way0
    do_req(16'h1234, 0, 1);
    check_val("whit_lat", 64'(lat), 64'd1);
    check_val("whit_td", 64'(r_td), 64'h01);
    check_val("whit_din", 64'(r_din), 64'h01);
    check_val("whit_lru_in", 64'(r_lru), 64'b0001011);
    do_req(16'h1234, 1, 0);
    check_val("after_whit_dout0", 64'(r_dout[0]), 64'd1);

    // Fill set 1 with tags 0x10..0x17 by writes; 0x12 already lives in way0
    for (int t = 0; t < 8; t++) fill_lat[t] = 8'(PM_LAT + 2);
    fill_lat[2] = 8'd1;
    for (int t = 0; t < 8; t++) begin
      do_req({8'(8'h10 + t), 8'h20}, 0, 1);
      check_val($sformatf("fill_lat_t%0d", t), 64'(lat), 64'(fill_lat[t]));
    end

    // All ways valid+dirty: PLRU victim is way1, written back then refilled
    do_req(16'h2020, 0, 1);
    check_val("dirty_wb", 64'(wb_seen), 64'd1);
    check_val("dirty_wb_asel", 64'(wb_asel), 64'd2);
    check_val("dirty_wb_dsel", 64'(wb_dsel), 64'd1);
    check_val("dirty_alloc", 64'(alloc_seen), 64'd1);
    check_val("dirty_alloc_asel", 64'(alloc_asel), 64'd0);
    check_val("dirty_lat", 64'(lat), 64'(2 * PM_LAT + 2));
    check_val("dirty_fill_v", 64'(fill_v), 64'h02);
    check_val("dirty_resp_dsel", 64'(r_dsel), 64'd1);
    check_val("dirty_resp_din", 64'(r_din), 64'h02);
    check_val("dirty_lru_in", 64'(r_lru), 64'b0000011);

    // Simultaneous read and write behaves as a write hit
    do_req(16'h2020, 1, 1);
    check_val("rw_lat", 64'(lat), 64'd1);
    check_val("rw_din", 64'(r_din), 64'h02);
    check_val("rw_dsel", 64'(r_dsel), 64'd1);
    check_val("rw_dout1", 64'(r_dout[1]), 64'd1);

`ifdef L2_PERF_CNT_EN
    @(negedge clk);
    check_val("perf_hit_count", 64'(hit_count), 64'(exp_hits));
    check_val("perf_miss_count", 64'(miss_count), 64'(exp_miss));
    @(posedge clk); #1;
`endif

    // Reset in the middle of ALLOCATE
    addr = 16'h0440; mem_read = 1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("pre_rst_pmem_read", 64'(pmem_read), 64'd1);
    @(posedge clk); #1;
    rst = 1; mem_read = 0;
    @(posedge clk); #1;
    rst = 0;
    exp_hits = 0; exp_miss = 0;
    @(negedge clk);
    check_val("rst_pmem_read", 64'(pmem_read), 64'd0);
    check_val("rst_state", 64'(dut.state_q), 64'(IDLE));
    check_val("rst_outputs",
              {6'd0, mem_resp, ctl, lru_in, pmemwdata_sel, pmemaddr_sel, pmem_read, pmem_write}, 64'd0);
    @(posedge clk); #1;

    do_req(16'h0440, 1, 0);
    check_val("post_rst_lat", 64'(lat), 64'(PM_LAT + 2));
    check_val("post_rst_fill_v", 64'(fill_v), 64'h01);
    check_val("post_rst_lru_in", 64'(r_lru), 64'b0001011);

`ifdef L2_PERF_CNT_EN
    @(negedge clk);
    check_val("perf_rst_hit_count", 64'(hit_count), 64'(exp_hits));
    check_val("perf_rst_miss_count", 64'(miss_count), 64'(exp_miss));
`endif

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
